// File: rtl/seq_pkg.sv
// Shared definitions for the bit serializer: FSM state encoding and default word width.
package seq_pkg;

  localparam int SEQ_DEFAULT_WIDTH = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/seq_hold_reg.sv
// One-entry hold register with full flag; parks the next word while the current one shifts.
module seq_hold_reg
  import seq_pkg::*;
#(
  parameter int WIDTH = SEQ_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             pop,
  output logic [WIDTH-1:0] word,
  output logic             full
);

  logic [WIDTH-1:0] word_d;
  logic [WIDTH-1:0] word_q;
  logic             full_d;
  logic             full_q;

  // Load and pop never coincide: load needs the entry empty, pop needs it full.
  always_comb begin
    word_d = word_q;
    full_d = full_q;
    if (load) begin
      word_d = load_data;
      full_d = 1'b1;
    end else if (pop) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // Hold word and full flag storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      full_q <= 1'b0;
    end else begin
      word_q <= word_d;
      full_q <= full_d;
    end
  end

  assign word = word_q;
  assign full = full_q;

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial converter with a one-word hold register for gapless back-to-back words.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = SEQ_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             underrun,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w[WIDTH-1];
    end else begin
      return w[0];
    end
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return {w[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, w[WIDTH-1:1]};
    end
  endfunction

  seq_state_e       state_d;
  seq_state_e       state_q;
  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    cnt_d;
  logic [CW-1:0]    cnt_q;
  logic             dout_d;
  logic             dout_q;
  logic             dout_valid_d;
  logic             dout_valid_q;
  logic             underrun_d;
  logic             underrun_q;

  logic             accept;
  logic             last_bit;
  logic             hold_load;
  logic             hold_pop;
  logic [WIDTH-1:0] hold_word;
  logic             hold_full;
  logic             load_en;
  logic [WIDTH-1:0] load_word;

  assign data_ready = ~hold_full & ~reset;
  assign accept     = data_valid & data_ready;
  assign last_bit   = (state_q == ST_SHIFT) && (cnt_q == LAST_IDX);
  assign hold_load  = accept && (state_q == ST_SHIFT) && !last_bit;
  assign hold_pop   = last_bit && hold_full;

  seq_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .load      (hold_load),
    .load_data (data_in),
    .pop       (hold_pop),
    .word      (hold_word),
    .full      (hold_full)
  );

  // Select which word (if any) starts shifting next; a held word has priority over a new one.
  always_comb begin
    load_en   = 1'b0;
    load_word = data_in;
    case (state_q)
      ST_IDLE: begin
        load_en   = accept;
        load_word = data_in;
      end
      ST_SHIFT: begin
        if (last_bit && hold_full) begin
          load_en   = 1'b1;
          load_word = hold_word;
        end else if (last_bit) begin
          load_en   = accept;
          load_word = data_in;
        end else begin
          load_en   = 1'b0;
          load_word = data_in;
        end
      end
      default: begin
        load_en   = 1'b0;
        load_word = data_in;
      end
    endcase
  end

  // Next-state and serial output logic; the shift register holds only the bits not yet sent.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    underrun_d   = 1'b0;
    if (load_en) begin
      state_d      = ST_SHIFT;
      dout_d       = lead_bit(load_word);
      shift_d      = advance(load_word);
      cnt_d        = '0;
      dout_valid_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          dout_d       = IDLE_BIT;
          dout_valid_d = 1'b0;
          cnt_d        = '0;
        end
        ST_SHIFT: begin
          if (last_bit) begin
            state_d      = ST_IDLE;
            dout_d       = IDLE_BIT;
            dout_valid_d = 1'b0;
            cnt_d        = '0;
            underrun_d   = 1'b1;
          end else begin
            dout_d  = lead_bit(shift_q);
            shift_d = advance(shift_q);
            cnt_d   = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d      = ST_IDLE;
          dout_d       = IDLE_BIT;
          dout_valid_d = 1'b0;
          cnt_d        = '0;
        end
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      dout_q       <= IDLE_BIT;
      dout_valid_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      underrun_q   <= underrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign underrun   = underrun_q;
  assign busy       = (state_q == ST_SHIFT) || hold_full;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench for seq_bit_serializer: MSB-first default instance plus an LSB-first, IDLE_BIT=1 instance.
module tb_seq_bit_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       dout;
  logic       dout_valid;
  logic       underrun;
  logic       busy;

  logic       data_valid_l;
  logic       data_ready_l;
  logic       dout_l;
  logic       dout_valid_l;
  logic       underrun_l;
  logic       busy_l;

  int         checks = 0;
  int         errors = 0;
  logic       exp_q[$];
  logic       exp_bit;
  logic       mon_en = 1'b0;

  logic [5:0] det_sr;
  logic       det_hit;

  seq_bit_serializer #(
    .WIDTH     (8),
    .MSB_FIRST (1'b1),
    .IDLE_BIT  (1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .underrun   (underrun),
    .busy       (busy)
  );

  seq_bit_serializer #(
    .WIDTH     (8),
    .MSB_FIRST (1'b0),
    .IDLE_BIT  (1'b1)
  ) dut_l (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid_l),
    .data_ready (data_ready_l),
    .dout       (dout_l),
    .dout_valid (dout_valid_l),
    .underrun   (underrun_l),
    .busy       (busy_l)
  );

  always #5 clk = ~clk;

  // Reference detector for pattern 100111 on the valid serial stream, registered flag.
  always @(posedge clk) begin
    if (reset) begin
      det_sr  <= 6'd0;
      det_hit <= 1'b0;
    end else begin
      det_hit <= dout_valid && ({det_sr[4:0], dout} == 6'b100111);
      det_sr  <= dout_valid ? {det_sr[4:0], dout} : 6'd0;
    end
  end

  // Scoreboard: every valid serial bit must match the next expected bit.
  always @(negedge clk) begin
    if (mon_en && dout_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_bit: dout_valid=1 dout=%b with no expected bit", dout);
      end else begin
        exp_bit = exp_q.pop_front();
        if (dout !== exp_bit) begin
          errors++;
          $display("FAIL serial_bit: dout=%b required %b", dout, exp_bit);
        end
      end
    end
  end

  task automatic send_word(input logic [7:0] w);
    int t = 0;
    data_in    = w;
    data_valid = 1'b1;
    while (data_ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (data_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: data_ready=%b required 1", data_ready);
    end
    for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
    @(posedge clk);
  endtask

  task automatic test_reset;
    reset        = 1'b1;
    data_valid   = 1'b0;
    data_valid_l = 1'b0;
    data_in      = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({dout, dout_valid, underrun, busy, data_ready} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_state: dout/valid/underrun/busy/ready=%b required 00000",
               {dout, dout_valid, underrun, busy, data_ready});
    end
    checks++;
    if ({dout_l, dout_valid_l, busy_l, data_ready_l} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_state_lsb: dout/valid/busy/ready=%b required 1000",
               {dout_l, dout_valid_l, busy_l, data_ready_l});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (data_ready !== 1'b1 || data_ready_l !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: data_ready=%b/%b required 1/1", data_ready, data_ready_l);
    end
    mon_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (underrun !== 1'b0 || dout_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_before_word: underrun=%b dout_valid=%b required 0 0", underrun, dout_valid);
      end
    end
  endtask

  task automatic test_single;
    logic exp_v;
    send_word(8'h9C);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        data_valid = 1'b0;
        data_in    = 8'h63;
      end
      if (k == 5) data_in = 8'hFF;
      exp_v = (k <= 8);
      checks++;
      if (dout_valid !== exp_v) begin
        errors++;
        $display("FAIL single_valid k=%0d: dout_valid=%b required %b", k, dout_valid, exp_v);
      end
      checks++;
      if (underrun !== (k == 9)) begin
        errors++;
        $display("FAIL single_underrun k=%0d: underrun=%b required %b", k, underrun, (k == 9));
      end
      checks++;
      if (busy !== exp_v) begin
        errors++;
        $display("FAIL single_busy k=%0d: busy=%b required %b", k, busy, exp_v);
      end
      if (k == 9) begin
        checks++;
        if (dout !== 1'b0) begin
          errors++;
          $display("FAIL single_idle_bit: dout=%b required 0", dout);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_drain: %0d bits outstanding required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back;
    logic exp_v;
    send_word(8'h9C);
    @(negedge clk);
    send_word(8'hE7);
    for (int k = 2; k <= 17; k++) begin
      @(negedge clk);
      if (k == 2) data_valid = 1'b0;
      exp_v = (k <= 16);
      checks++;
      if (dout_valid !== exp_v || underrun !== (k == 17)) begin
        errors++;
        $display("FAIL b2b_stream k=%0d: dout_valid=%b underrun=%b required %b %b",
                 k, dout_valid, underrun, exp_v, (k == 17));
      end
      if (k <= 8) begin
        checks++;
        if (data_ready !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_hold_full k=%0d: data_ready=%b busy=%b required 0 1", k, data_ready, busy);
        end
      end
      if (k == 9) begin
        checks++;
        if (data_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_hold_empty: data_ready=%b required 1", data_ready);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: %0d bits outstanding required 0", exp_q.size());
    end
  endtask

  task automatic test_last_bit_accept;
    logic exp_v;
    send_word(8'h9C);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) data_valid = 1'b0;
      checks++;
      if (underrun !== 1'b0) begin
        errors++;
        $display("FAIL lastbit_pre_underrun k=%0d: underrun=%b required 0", k, underrun);
      end
    end
    send_word(8'h5A);
    for (int k = 9; k <= 17; k++) begin
      @(negedge clk);
      if (k == 9) data_valid = 1'b0;
      exp_v = (k <= 16);
      checks++;
      if (dout_valid !== exp_v || underrun !== (k == 17)) begin
        errors++;
        $display("FAIL lastbit_stream k=%0d: dout_valid=%b underrun=%b required %b %b",
                 k, dout_valid, underrun, exp_v, (k == 17));
      end
    end
  endtask

  task automatic test_lsb_first;
    logic lq[$];
    logic eb;
    int   t = 0;
    data_in      = 8'h39;
    data_valid_l = 1'b1;
    while (data_ready_l !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 8; i++) lq.push_back(data_in[i]);
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) begin
        data_valid_l = 1'b0;
        data_in      = 8'hC6;
      end
      if (k <= 8) begin
        eb = lq.pop_front();
        checks++;
        if (dout_valid_l !== 1'b1 || dout_l !== eb) begin
          errors++;
          $display("FAIL lsb_bit k=%0d: dout_valid=%b dout=%b required 1 %b", k, dout_valid_l, dout_l, eb);
        end
      end else begin
        checks++;
        if ({dout_l, dout_valid_l, underrun_l} !== 3'b101) begin
          errors++;
          $display("FAIL lsb_idle: dout/valid/underrun=%b required 101", {dout_l, dout_valid_l, underrun_l});
        end
      end
    end
  endtask

  task automatic test_reset_mid_word;
    send_word(8'h9C);
    @(negedge clk);
    send_word(8'hE7);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      if (k == 2) data_valid = 1'b0;
    end
    mon_en = 1'b0;
    reset  = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if ({dout, dout_valid, underrun, busy, data_ready} !== 5'b00000) begin
      errors++;
      $display("FAIL midreset_state: dout/valid/underrun/busy/ready=%b required 00000",
               {dout, dout_valid, underrun, busy, data_ready});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (data_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready: data_ready=%b required 1", data_ready);
    end
    mon_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if ({dout, dout_valid, underrun, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL midreset_quiet: dout/valid/underrun/busy=%b required 0000",
                 {dout, dout_valid, underrun, busy});
      end
    end
  endtask

  task automatic test_detector;
    int hits  = 0;
    int hit_k = -1;
    send_word(8'h9C);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) data_valid = 1'b0;
      if (det_hit === 1'b1) begin
        hits++;
        hit_k = k;
      end
    end
    checks++;
    if (hits != 1 || hit_k != 7) begin
      errors++;
      $display("FAIL detector: hits=%0d at cycle %0d required 1 at cycle 7", hits, hit_k);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_last_bit_accept();
    test_lsb_first();
    test_reset_mid_word();
    test_detector();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_drain: %0d bits outstanding required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
